// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg -- shared constants for the RV32I instruction decode stage.
//
// Holds the datapath widths, the base-ISA opcode map, the funct3/funct7
// encodings the decoder needs for legality checks, and a helper that
// validates a funct7/funct3 pair for register-register ALU instructions.
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Major opcodes (inst[6:0]) of RV32I handled by the decoder.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3 encodings referenced by the legality checks.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_BR_RSV0 = 3'b010;
    localparam logic [2:0] F3_BR_RSV1 = 3'b011;
    localparam logic [2:0] F3_LD_RSV0 = 3'b011;
    localparam logic [2:0] F3_LD_RSV1 = 3'b110;
    localparam logic [2:0] F3_LD_RSV2 = 3'b111;
    localparam logic [2:0] F3_ST_MAX  = 3'b010;  // SW is the widest store

    // funct7 encodings: base form and the alternate (SUB/SRA/SRAI) form.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Only ADD/SUB and SRL/SRA have an alternate funct7 form in RV32I.
    function automatic logic op_pair_legal(input logic [6:0] f7, input logic [2:0] f3);
        return (f7 == F7_BASE) ||
               ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// -----------------------------------------------------------------------------
// id_imm_gen -- extracts the I-, S- and U-type immediates of an RV32I word.
//
// Ports:
//   inst_i   in   XLEN  instruction word
//   imm_i_o  out  XLEN  sign-extended inst[31:20]
//   imm_s_o  out  XLEN  sign-extended {inst[31:25], inst[11:7]}
//   imm_u_o  out  XLEN  {inst[31:12], 12'h000}
// -----------------------------------------------------------------------------
import id_pkg::*;

module id_imm_gen (
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] imm_i_o,
    output logic [XLEN-1:0] imm_s_o,
    output logic [XLEN-1:0] imm_u_o
);

    assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_u_o = {inst_i[31:12], 12'h000};

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst_i[6:0];

endmodule

// File: rtl/id.sv
// -----------------------------------------------------------------------------
// id -- RV32I instruction decode stage.
//
// Purely combinational decode of one instruction word into register-file read
// addresses, the two execute operands and the destination register. An
// optional legality checker flags undecodable words and keeps a sticky flag.
//
// Configuration:
//   ID_ILLEGAL_CHECK_EN  defined   -> illegal_inst_o / illegal_seen_o live
//                        undefined -> both tied to 0, no flop is built
//
// Ports:
//   clk             in   1     clock (only the sticky illegal flag uses it)
//   rst_n           in   1     asynchronous active-low reset
//   inst_i          in   32    instruction word
//   inst_addr_i     in   32    address of inst_i
//   reg1_rdata_i    in   32    register-file data for reg1_raddr_o
//   reg2_rdata_i    in   32    register-file data for reg2_raddr_o
//   op1_o           out  32    first execute operand
//   op2_o           out  32    second execute operand
//   inst_o          out  32    inst_i passed through
//   inst_addr_o     out  32    inst_addr_i passed through
//   reg1_raddr_o    out  5     rs1 read address
//   reg2_raddr_o    out  5     rs2 read address
//   reg_waddr_o     out  5     rd write address, 0 = no write
//   illegal_inst_o  out  1     current inst_i is not decodable
//   illegal_seen_o  out  1     sticky: illegal instruction sampled since reset
// -----------------------------------------------------------------------------
import id_pkg::*;

module id (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       inst_i,
    input  logic [XLEN-1:0]       inst_addr_i,
    input  logic [XLEN-1:0]       reg1_rdata_i,
    input  logic [XLEN-1:0]       reg2_rdata_i,
    output logic [XLEN-1:0]       op1_o,
    output logic [XLEN-1:0]       op2_o,
    output logic [XLEN-1:0]       inst_o,
    output logic [XLEN-1:0]       inst_addr_o,
    output logic [REG_ADDR_W-1:0] reg1_raddr_o,
    output logic [REG_ADDR_W-1:0] reg2_raddr_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  illegal_inst_o,
    output logic                  illegal_seen_o
);

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       imm_i;
    logic [XLEN-1:0]       imm_s;
    logic [XLEN-1:0]       imm_u;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];

    assign inst_o      = inst_i;
    assign inst_addr_o = inst_addr_i;

    id_imm_gen u_imm_gen (
        .inst_i  (inst_i),
        .imm_i_o (imm_i),
        .imm_s_o (imm_s),
        .imm_u_o (imm_u)
    );

    // Decode mux. rd = x0 is reported as-is; the register file ignores it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        op1_o        = '0;
        op2_o        = '0;
        reg1_raddr_o = '0;
        reg2_raddr_o = '0;
        reg_waddr_o  = '0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD: begin
                // Shift immediates keep funct7 in op2; execute masks shamt.
                reg1_raddr_o = rs1;
                op1_o        = reg1_rdata_i;
                op2_o        = imm_i;
                reg_waddr_o  = rd;
            end
            OPC_OP: begin
                reg1_raddr_o = rs1;
                reg2_raddr_o = rs2;
                op1_o        = reg1_rdata_i;
                op2_o        = reg2_rdata_i;
                reg_waddr_o  = rd;
            end
            OPC_STORE: begin
                reg1_raddr_o = rs1;
                reg2_raddr_o = rs2;
                op1_o        = reg1_rdata_i;
                op2_o        = imm_s;
            end
            OPC_BRANCH: begin
                reg1_raddr_o = rs1;
                reg2_raddr_o = rs2;
                op1_o        = reg1_rdata_i;
                op2_o        = reg2_rdata_i;
            end
            OPC_LUI: begin
                op2_o       = imm_u;
                reg_waddr_o = rd;
            end
            OPC_AUIPC: begin
                op1_o       = inst_addr_i;
                op2_o       = imm_u;
                reg_waddr_o = rd;
            end
            OPC_JAL, OPC_JALR: begin
                // Operands form the link value pc+4; the target is computed
                // elsewhere.
                if (opcode == OPC_JALR) begin
                    reg1_raddr_o = rs1;
                end
                op1_o       = inst_addr_i;
                op2_o       = 32'h0000_0004;
                reg_waddr_o = rd;
            end
            default: ;
        endcase
    end

`ifdef ID_ILLEGAL_CHECK_EN

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal_inst;
    logic       illegal_seen_d;
    logic       illegal_seen_q;

    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        illegal_inst = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            illegal_inst = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM: begin
                    if (funct3 == F3_SLL) begin
                        illegal_inst = (funct7 != F7_BASE);
                    end else if (funct3 == F3_SRL_SRA) begin
                        illegal_inst = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                end
                OPC_OP:     illegal_inst = !op_pair_legal(funct7, funct3);
                OPC_BRANCH: illegal_inst = (funct3 == F3_BR_RSV0) || (funct3 == F3_BR_RSV1);
                OPC_LOAD:   illegal_inst = (funct3 == F3_LD_RSV0) || (funct3 == F3_LD_RSV1) ||
                                           (funct3 == F3_LD_RSV2);
                OPC_STORE:  illegal_inst = (funct3 > F3_ST_MAX);
                OPC_JALR:   illegal_inst = (funct3 != F3_JALR);
                OPC_LUI, OPC_AUIPC, OPC_JAL: illegal_inst = 1'b0;
                default:    illegal_inst = 1'b1;
            endcase
        end
    end

    assign illegal_seen_d = illegal_seen_q | illegal_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment for state so every flop samples the
        // pre-edge values, independent of block evaluation order.
        if (!rst_n) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_inst_o = illegal_inst;
    assign illegal_seen_o = illegal_seen_q;

`else

    assign illegal_inst_o = 1'b0;
    assign illegal_seen_o = 1'b0;

    // Clock and reset only feed the checker; sink them when it is absent.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

`endif

endmodule

// File: tb/tb_id.sv
// -----------------------------------------------------------------------------
// tb_id -- directed-vector bench for the RV32I decode stage.
// Expected values are hand-computed from the instruction encodings. The
// illegal-flag expectations follow ID_ILLEGAL_CHECK_EN as seen by this file.
// -----------------------------------------------------------------------------
module tb_id;

`ifdef ID_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] reg1_rdata_i;
    logic [31:0] reg2_rdata_i;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [4:0]  reg1_raddr_o;
    logic [4:0]  reg2_raddr_o;
    logic [4:0]  reg_waddr_o;
    logic        illegal_inst_o;
    logic        illegal_seen_o;

    int n_vec  = 0;
    int n_miss = 0;

    id dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_i         (inst_i),
        .inst_addr_i    (inst_addr_i),
        .reg1_rdata_i   (reg1_rdata_i),
        .reg2_rdata_i   (reg2_rdata_i),
        .op1_o          (op1_o),
        .op2_o          (op2_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .reg1_raddr_o   (reg1_raddr_o),
        .reg2_raddr_o   (reg2_raddr_o),
        .reg_waddr_o    (reg_waddr_o),
        .illegal_inst_o (illegal_inst_o),
        .illegal_seen_o (illegal_seen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic        ill;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one vector away from the clock edge and compare every decode output.
    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        inst_i       = v.inst;
        inst_addr_i  = v.addr;
        reg1_rdata_i = v.r1;
        reg2_rdata_i = v.r2;
        #1;
        check({name, ".op1"},   op1_o, v.op1);
        check({name, ".op2"},   op2_o, v.op2);
        check({name, ".ra1"},   32'(reg1_raddr_o), 32'(v.ra1));
        check({name, ".ra2"},   32'(reg2_raddr_o), 32'(v.ra2));
        check({name, ".wa"},    32'(reg_waddr_o), 32'(v.wa));
        check({name, ".ill"},   32'(illegal_inst_o), 32'(v.ill & ILL_EN));
        check({name, ".inst"},  inst_o, v.inst);
        check({name, ".iaddr"}, inst_addr_o, v.addr);
    endtask

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    vec_t legal_v[11];
    vec_t illegal_v[10];

    initial begin
        //                inst          addr          r1            r2    op1           op2           ra1 ra2 wa ill
        legal_v[0]  = '{32'hfff08013, 32'h0000_0000, 32'h42,      R2,   32'h42,       32'hffffffff, 1,  0,  0, 0}; // addi x0,x1,-1
        legal_v[1]  = '{32'h4098d813, 32'h0000_0000, 32'h80000000,R2,   32'h80000000, 32'h00000409, 17, 0, 16, 0}; // srai x16,x17,9
        legal_v[2]  = '{32'h002081b3, 32'h0000_0000, 32'h42,      32'h69, 32'h42,     32'h69,       1,  2,  3, 0}; // add x3,x1,x2
        legal_v[3]  = '{32'h12345297, 32'h0000_0123, R1,          R2,   32'h123,      32'h12345000, 0,  0,  5, 0}; // auipc x5
        legal_v[4]  = '{32'hfffff3b7, 32'h0000_0040, R1,          R2,   32'h0,        32'hfffff000, 0,  0,  7, 0}; // lui x7
        legal_v[5]  = '{32'h008000ef, 32'h0000_1000, R1,          R2,   32'h1000,     32'h4,        0,  0,  1, 0}; // jal x1,8
        legal_v[6]  = '{32'h000280e7, 32'h0000_2000, R1,          R2,   32'h2000,     32'h4,        5,  0,  1, 0}; // jalr x1,0(x5)
        legal_v[7]  = '{32'hffc12303, 32'h0000_0000, R1,          R2,   R1,           32'hfffffffc, 2,  0,  6, 0}; // lw x6,-4(x2)
        legal_v[8]  = '{32'hfe71ac23, 32'h0000_0000, R1,          R2,   R1,           32'hfffffff8, 3,  7,  0, 0}; // sw x7,-8(x3)
        legal_v[9]  = '{32'h00208463, 32'h0000_0000, R1,          R2,   R1,           R2,           1,  2,  0, 0}; // beq x1,x2,8
        legal_v[10] = '{32'h40c58533, 32'h0000_0000, R1,          R2,   R1,           R2,          11, 12, 10, 0}; // sub x10,x11,x12

        illegal_v[0] = '{32'h402091b3, 32'h0, R1, R2, R1,   R2,           1,  2,  3, 1}; // OP f7=0100000 f3=001
        illegal_v[1] = '{32'h40109093, 32'h0, R1, R2, R1,   32'h00000401, 1,  0,  1, 1}; // slli f7!=0
        illegal_v[2] = '{32'h0298d813, 32'h0, R1, R2, R1,   32'h00000029, 17, 0, 16, 1}; // srli f7=0000001
        illegal_v[3] = '{32'h0020a463, 32'h0, R1, R2, R1,   R2,           1,  2,  0, 1}; // branch f3=010
        illegal_v[4] = '{32'hffc13303, 32'h0, R1, R2, R1,   32'hfffffffc, 2,  0,  6, 1}; // load f3=011
        illegal_v[5] = '{32'hfe71bc23, 32'h0, R1, R2, R1,   32'hfffffff8, 3,  7,  0, 1}; // store f3=011
        illegal_v[6] = '{32'h000290e7, 32'h300, R1, R2, 32'h300, 32'h4,   5,  0,  1, 1}; // jalr f3=001
        illegal_v[7] = '{32'h0000000f, 32'h0, R1, R2, 32'h0, 32'h0,       0,  0,  0, 1}; // fence (unlisted)
        illegal_v[8] = '{32'h00000073, 32'h0, R1, R2, 32'h0, 32'h0,       0,  0,  0, 1}; // ecall (unlisted)
        illegal_v[9] = '{32'h00000000, 32'h0, R1, R2, 32'h0, 32'h0,       0,  0,  0, 1}; // all-zero word

        // Hold a legal word during reset so the sticky flag has nothing to catch.
        rst_n        = 1'b0;
        inst_i       = 32'h002081b3;
        inst_addr_i  = '0;
        reg1_rdata_i = '0;
        reg2_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.seen", 32'(illegal_seen_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (legal_v[i]) run_vec($sformatf("legal%0d", i), legal_v[i]);
        @(posedge clk);
        #1;
        check("legal.seen", 32'(illegal_seen_o), 32'h0);

        foreach (illegal_v[i]) begin
            run_vec($sformatf("illegal%0d", i), illegal_v[i]);
            // One edge with the word present is enough to make the flag stick.
            @(posedge clk);
            #1;
            check($sformatf("illegal%0d.seen", i), 32'(illegal_seen_o), 32'(ILL_EN));
        end

        // Return to a legal word: the flag must stay set.
        run_vec("after_ill", legal_v[2]);
        @(posedge clk);
        #1;
        check("sticky.seen", 32'(illegal_seen_o), 32'(ILL_EN));

        // Reset clears immediately without a clock edge; decode is unaffected.
        @(negedge clk);
        inst_i = 32'h00000000;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.seen", 32'(illegal_seen_o), 32'h0);
        check("async_rst.ill", 32'(illegal_inst_o), 32'(ILL_EN));
        check("async_rst.op1", op1_o, 32'h0);
        @(posedge clk);
        #1;
        check("in_rst.seen", 32'(illegal_seen_o), 32'h0);

        // Release mid-illegal: flag sets at the next rising edge, not before.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.seen", 32'(illegal_seen_o), 32'h0);
        @(posedge clk);
        #1;
        check("release_edge.seen", 32'(illegal_seen_o), 32'(ILL_EN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id.md
ID -- requirements
Module: id

Interface
REQ-001 clk  input  1  single clock; used only by the illegal-instruction sticky flag.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 inst_i  input  32  RV32I instruction word.
REQ-004 inst_addr_i  input  32  address of inst_i.
REQ-005 reg1_rdata_i  input  32  register-file data for reg1_raddr_o.
REQ-006 reg2_rdata_i  input  32  register-file data for reg2_raddr_o.
REQ-007 op1_o  output  32  first execute operand.
REQ-008 op2_o  output  32  second execute operand.
REQ-009 inst_o  output  32  inst_i passed through.
REQ-010 inst_addr_o  output  32  inst_addr_i passed through.
REQ-011 reg1_raddr_o  output  5  rs1 read address.
REQ-012 reg2_raddr_o  output  5  rs2 read address.
REQ-013 reg_waddr_o  output  5  rd write address; 0 = no write.
REQ-014 illegal_inst_o  output  1  current inst_i not decodable.
REQ-015 illegal_seen_o  output  1  sticky: an illegal instruction was sampled since reset.

Function
REQ-016 All decode outputs SHALL be purely combinational from inputs, zero-cycle latency; inst_o/inst_addr_o SHALL equal inputs unchanged.
REQ-017 Immediates: I=sext(inst[31:20]); S=sext({inst[31:25],inst[11:7]}); U={inst[31:12],12'h0}; sext to 32 bits from bit 31.
REQ-018 OP-IMM (0010011), all funct3 incl. shifts: raddr1=rs1, raddr2=0, op1=reg1_rdata_i, op2=I-imm unmodified (srai x16,x17,9 gives 0x409), waddr=rd.
REQ-019 OP (0110011): raddr1=rs1, raddr2=rs2, op1=reg1_rdata_i, op2=reg2_rdata_i, waddr=rd.
REQ-020 LOAD (0000011): raddr1=rs1, raddr2=0, op1=reg1_rdata_i, op2=I-imm, waddr=rd.
REQ-021 STORE (0100011): raddr1=rs1, raddr2=rs2, op1=reg1_rdata_i, op2=S-imm, waddr=0.
REQ-022 BRANCH (1100011): raddr1=rs1, raddr2=rs2, op1=reg1_rdata_i, op2=reg2_rdata_i, waddr=0.
REQ-023 LUI (0110111): raddr 0/0, op1=0, op2=U-imm, waddr=rd.
REQ-024 AUIPC (0010111): raddr 0/0, op1=inst_addr_i, op2=U-imm, waddr=rd.
REQ-025 JAL (1101111): raddr 0/0; JALR (1100111): raddr1=rs1, raddr2=0; both op1=inst_addr_i, op2=32'h4, waddr=rd.
REQ-026 Any other opcode: op1, op2, raddr1, raddr2, waddr all 0.
REQ-027 illegal_inst_o SHALL be 1 for: unlisted opcode; inst[1:0]!=2'b11; slli with inst[31:25]!=0; srli/srai with inst[31:25] not 0/0100000; OP with invalid funct7/funct3 pair; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>=011; JALR funct3!=0.
REQ-028 illegal_seen_o SHALL set on any rising clk where illegal_inst_o=1 and hold until reset.
REQ-029 rd=x0 SHALL still be reported as waddr 0 (no special casing).

Reset
REQ-030 rst_n low SHALL clear illegal_seen_o immediately; decode outputs are unaffected by reset.
REQ-031 Reset release mid-illegal instruction SHALL set illegal_seen_o at the next rising clk.

Configuration
REQ-032 Macro ID_ILLEGAL_CHECK_EN defined: REQ-027/028 implemented.
REQ-033 Macro undefined: illegal_inst_o and illegal_seen_o tied 0, no flop; all other behaviour identical.

Structure
REQ-034 Shared package SHALL hold opcode constants, funct3/funct7 constants, XLEN=32, REG_ADDR_W=5.
REQ-035 One sub-module id_imm_gen (I/S/U immediate extraction) is natural; decode mux stays in id.

Verification
REQ-036 addi x0,x1,-1 (0xfff08013), reg1=0x42 -> op1=0x42, op2=0xffffffff, raddr1=1, raddr2=0, waddr=0.
REQ-037 srai x16,x17,9 (0x4098d813) -> op2=0x409, raddr1=0x11, waddr=0x10, illegal=0.
REQ-038 add x3,x1,x2 (0x002081b3), reg1=0x42, reg2=0x69 -> op1=0x42, op2=0x69, raddr 1/2, waddr=3.
REQ-039 auipc x5,0x12345 (0x12345297), addr=0x123 -> op1=0x123, op2=0x12345000, waddr=5.
REQ-040 0x00000000 then clk edge -> all decode outputs 0, illegal_inst_o=1, illegal_seen_o=1; rst_n low -> illegal_seen_o=0 without clock.
